// File: rtl/set_lattice_counter_pkg.sv
// Shared definitions for the lattice-point counter: mode codes, FSM encoding
// and a popcount helper for the exact-k set expressions.
package set_lattice_pkg;

  localparam logic [2:0] MODE_A       = 3'd0;
  localparam logic [2:0] MODE_AND_AB  = 3'd1;
  localparam logic [2:0] MODE_XOR_AB  = 3'd2;
  localparam logic [2:0] MODE_TWO_ABC = 3'd3;
  localparam logic [2:0] MODE_OR_ALL  = 3'd4;
  localparam logic [2:0] MODE_AND_ALL = 3'd5;
  localparam logic [2:0] MODE_ONE_ALL = 3'd6;
  localparam logic [2:0] MODE_RSVD    = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/set_lattice_counter_if.sv
// Job interface of the lattice counter: circle/mode configuration in,
// busy/valid/candidate status out.
interface set_lattice_counter_if #(
  parameter int COORD_W  = 4,
  parameter int NUM_SETS = 3,
  parameter int CNT_W    = 8
);
  logic                           en;
  logic [NUM_SETS*2*COORD_W-1:0]  central;
  logic [NUM_SETS*COORD_W-1:0]    radius;
  logic [2:0]                     mode;
  logic                           busy;
  logic                           valid;
  logic [CNT_W-1:0]               candidate;

  modport master (output en, central, radius, mode, input busy, valid, candidate);
  modport slave  (input en, central, radius, mode, output busy, valid, candidate);
endinterface

// File: rtl/set_lattice_counter_member_check.sv
// Combinational circle membership: (dx^2 + dy^2) <= r^2 with one spare bit so
// the sum of squares never overflows.
module set_member_check #(
  parameter int COORD_W = 4
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [COORD_W-1:0] i_cx,
  input  logic [COORD_W-1:0] i_cy,
  input  logic [COORD_W-1:0] i_r,
  output logic               o_member
);
  localparam int SQ_W = 2*COORD_W + 1;

  logic [COORD_W-1:0] w_dx, w_dy;
  logic [SQ_W-1:0]    w_dx_ext, w_dy_ext, w_r_ext;
  logic [SQ_W-1:0]    w_dist2, w_r2;

  assign w_dx     = (i_x >= i_cx) ? (i_x - i_cx) : (i_cx - i_x);
  assign w_dy     = (i_y >= i_cy) ? (i_y - i_cy) : (i_cy - i_y);
  assign w_dx_ext = {{(COORD_W+1){1'b0}}, w_dx};
  assign w_dy_ext = {{(COORD_W+1){1'b0}}, w_dy};
  assign w_r_ext  = {{(COORD_W+1){1'b0}}, i_r};
  assign w_dist2  = w_dx_ext * w_dx_ext + w_dy_ext * w_dy_ext;
  assign w_r2     = w_r_ext * w_r_ext;
  assign o_member = (w_dist2 <= w_r2);
endmodule

// File: rtl/set_lattice_counter.sv
// Scans a GRID x GRID lattice one point per cycle and counts the points that
// satisfy the selected set expression over NUM_SETS circles.
//   state   | meaning
//   ST_IDLE | waiting for en; candidate holds last result
//   ST_SCAN | visiting (x,y), x inner, accumulating hits
//   ST_DONE | one-cycle valid pulse with final count
module set_lattice_counter
  import set_lattice_pkg::*;
#(
  parameter int GRID     = 8,
  parameter int COORD_W  = 4,
  parameter int NUM_SETS = 3,
  parameter int CNT_W    = 8
) (
  input logic                 clk,
  input logic                 rst,
  set_lattice_counter_if.slave bus
);
  localparam logic [COORD_W-1:0] GRID_C = COORD_W'(GRID);
  localparam logic [COORD_W-1:0] ONE_C  = COORD_W'(1);

  logic [1:0]                    r_state;
  logic [COORD_W-1:0]            r_x, r_y;
  logic [NUM_SETS*2*COORD_W-1:0] r_central;
  logic [NUM_SETS*COORD_W-1:0]   r_radius;
  logic [2:0]                    r_mode;
  logic [CNT_W-1:0]              r_cnt;
  logic [NUM_SETS-1:0]           w_m;
  logic                          w_hit;

  // Set 0 sits in the most significant slot of the packed buses.
  for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set
    localparam int SLOT = NUM_SETS - 1 - gi;
    set_member_check #(.COORD_W(COORD_W)) u_chk (
      .i_x      (r_x),
      .i_y      (r_y),
      .i_cx     (r_central[(2*SLOT+1)*COORD_W +: COORD_W]),
      .i_cy     (r_central[2*SLOT*COORD_W +: COORD_W]),
      .i_r      (r_radius[SLOT*COORD_W +: COORD_W]),
      .o_member (w_m[gi])
    );
  end

  always_comb begin
    w_hit = 1'b0;
    case (r_mode)
      MODE_A:       w_hit = w_m[0];
      MODE_AND_AB:  w_hit = w_m[0] & w_m[1];
      MODE_XOR_AB:  w_hit = w_m[0] ^ w_m[1];
      MODE_TWO_ABC: w_hit = (popcount(8'(w_m[2:0])) == 4'd2);
      MODE_OR_ALL:  w_hit = |w_m;
      MODE_AND_ALL: w_hit = &w_m;
      MODE_ONE_ALL: w_hit = (popcount(8'(w_m)) == 4'd1);
      default:      w_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_x       <= ONE_C;
      r_y       <= ONE_C;
      r_central <= '0;
      r_radius  <= '0;
      r_mode    <= MODE_A;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.en) begin
            r_central <= bus.central;
            r_radius  <= bus.radius;
            r_mode    <= bus.mode;
            r_cnt     <= '0;
            r_state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_hit) r_cnt <= r_cnt + CNT_W'(1);
          if (r_x == GRID_C) begin
            r_x <= ONE_C;
            if (r_y == GRID_C) begin
              r_y     <= ONE_C;
              r_state <= ST_DONE;
            end else begin
              r_y <= r_y + ONE_C;
            end
          end else begin
            r_x <= r_x + ONE_C;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.valid     = (r_state == ST_DONE);
  assign bus.candidate = r_cnt;
endmodule

// File: tb/tb_set_lattice_counter.sv
// Self-checking bench: directed cases plus random jobs compared against an
// arithmetic lattice-count model.
module tb_set_lattice_counter;
  localparam int GRID     = 8;
  localparam int COORD_W  = 4;
  localparam int NUM_SETS = 3;
  localparam int CNT_W    = 8;
  localparam int LAT      = GRID*GRID + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  set_lattice_counter_if #(.COORD_W(COORD_W), .NUM_SETS(NUM_SETS), .CNT_W(CNT_W)) u_if ();

  set_lattice_counter #(.GRID(GRID), .COORD_W(COORD_W), .NUM_SETS(NUM_SETS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int checks = 0;
  int errors = 0;

  int t_cx [NUM_SETS];
  int t_cy [NUM_SETS];
  int t_r  [NUM_SETS];
  int t_md;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model();
    int n = 0;
    for (int y = 1; y <= GRID; y++) begin
      for (int x = 1; x <= GRID; x++) begin
        int m [NUM_SETS];
        int k;
        bit hit;
        k = 0;
        for (int i = 0; i < NUM_SETS; i++) begin
          m[i] = ((x - t_cx[i])*(x - t_cx[i]) + (y - t_cy[i])*(y - t_cy[i]) <= t_r[i]*t_r[i]) ? 1 : 0;
          k += m[i];
        end
        case (t_md)
          0: hit = (m[0] == 1);
          1: hit = (m[0] + m[1] == 2);
          2: hit = (m[0] + m[1] == 1);
          3: hit = (m[0] + m[1] + m[2] == 2);
          4: hit = (k >= 1);
          5: hit = (k == NUM_SETS);
          6: hit = (k == 1);
          default: hit = 1'b0;
        endcase
        if (hit) n++;
      end
    end
    return n;
  endfunction

  task automatic set_job(input int ax, input int ay, input int ar,
                         input int bx, input int by, input int br,
                         input int cx, input int cy, input int cr, input int md);
    t_cx[0] = ax; t_cy[0] = ay; t_r[0] = ar;
    t_cx[1] = bx; t_cy[1] = by; t_r[1] = br;
    t_cx[2] = cx; t_cy[2] = cy; t_r[2] = cr;
    t_md = md;
  endtask

  task automatic drive_inputs();
    u_if.central = '0;
    u_if.radius  = '0;
    for (int i = 0; i < NUM_SETS; i++) begin
      u_if.central[(2*(NUM_SETS-1-i)+1)*COORD_W +: COORD_W] = COORD_W'(t_cx[i]);
      u_if.central[2*(NUM_SETS-1-i)*COORD_W +: COORD_W]     = COORD_W'(t_cy[i]);
      u_if.radius[(NUM_SETS-1-i)*COORD_W +: COORD_W]        = COORD_W'(t_r[i]);
    end
    u_if.mode = 3'(t_md);
  endtask

  // exp < 0 means take the expected count from the model
  task automatic run_job(input string tag, input int exp_in, input bit inject);
    int exp;
    int cyc;
    bit busy_ok;
    exp = (exp_in < 0) ? model() : exp_in;
    @(negedge clk);
    drive_inputs();
    u_if.en = 1'b1;
    @(negedge clk);
    u_if.en = 1'b0;
    cyc = 1;
    busy_ok = 1'b1;
    while (!u_if.valid && cyc < 200) begin
      if (!u_if.busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
      if (inject && cyc == 10) begin
        u_if.en      = 1'b1;
        u_if.mode    = ~u_if.mode;
        u_if.central = ~u_if.central;
        u_if.radius  = ~u_if.radius;
      end else begin
        u_if.en = 1'b0;
      end
    end
    u_if.en = 1'b0;
    check({tag, " latency"}, cyc, LAT);
    check({tag, " busy"}, int'(busy_ok && u_if.busy), 1);
    check({tag, " candidate"}, int'(u_if.candidate), exp);
    @(negedge clk);
    check({tag, " valid_drop"}, int'(u_if.valid), 0);
    check({tag, " busy_drop"}, int'(u_if.busy), 0);
    check({tag, " hold"}, int'(u_if.candidate), exp);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    u_if.en = 1'b0;
    u_if.central = '0;
    u_if.radius = '0;
    u_if.mode = '0;
    repeat (3) @(negedge clk);
    check("reset busy", int'(u_if.busy), 0);
    check("reset valid", int'(u_if.valid), 0);
    check("reset candidate", int'(u_if.candidate), 0);
    rst = 1'b0;

    set_job(4, 4, 0, 0, 0, 0, 0, 0, 0, 0); run_job("m0 r0", 1, 1'b0);
    set_job(4, 4, 2, 0, 0, 0, 0, 0, 0, 0); run_job("m0 r2", 13, 1'b0);
    set_job(1, 1, 15, 0, 0, 0, 0, 0, 0, 0); run_job("m0 full", 64, 1'b0);
    set_job(4, 4, 2, 4, 4, 2, 0, 0, 0, 1); run_job("m1 same", 13, 1'b0);
    set_job(4, 4, 2, 4, 4, 2, 0, 0, 0, 2); run_job("m2 same", 0, 1'b0);
    set_job(4, 4, 2, 8, 8, 0, 1, 1, 0, 4); run_job("m4 or", 15, 1'b0);
    set_job(4, 4, 2, 8, 8, 0, 1, 1, 0, 5); run_job("m5 and", 0, 1'b0);
    set_job(1, 1, 15, 4, 4, 9, 2, 3, 7, 7); run_job("m7 rsvd", 0, 1'b0);
    set_job(4, 4, 2, 0, 0, 0, 0, 0, 0, 0); run_job("en in scan", 13, 1'b1);

    // reset in the middle of a scan aborts the job without a valid pulse
    set_job(1, 1, 15, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive_inputs();
    u_if.en = 1'b1;
    @(negedge clk);
    u_if.en = 1'b0;
    repeat (19) @(negedge clk);
    check("pre-abort busy", int'(u_if.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", int'(u_if.busy), 0);
    check("abort valid", int'(u_if.valid), 0);
    check("abort candidate", int'(u_if.candidate), 0);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (u_if.valid || u_if.busy) seen++;
    end
    check("abort no pulse", seen, 0);

    set_job(4, 4, 2, 0, 0, 0, 0, 0, 0, 0); run_job("after rst", 13, 1'b0);

    for (int j = 0; j < 14; j++) begin
      set_job($urandom_range(15), $urandom_range(15), $urandom_range(15),
              $urandom_range(15), $urandom_range(15), $urandom_range(15),
              $urandom_range(15), $urandom_range(15), $urandom_range(15),
              (j < 8) ? j : $urandom_range(7));
      run_job($sformatf("rand%0d m%0d", j, t_md), -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
